// File: rtl/debug_ocimem_pkg.sv
// Shared types and jdo field positions for the on-chip debug memory controller.
package debug_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR      = 2'd2
  } state_e;

  localparam int CLR_ERR_BIT = 35;
  localparam int RD_REQ_BIT  = 34;
  localparam int ADDR_LSB    = 17;
  localparam int WDATA_LSB   = 3;

endpackage

// File: rtl/debug_ocimem_ctrl_if.sv
// Debug RAM port bundle: the controller drives address/data/strobes, the RAM returns read data.
interface debug_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  import debug_ocimem_pkg::*;

  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;

  modport master (
    output ram_addr, ram_wdata, ram_we, ram_re,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_we, ram_re,
    output ram_rdata
  );

endinterface

// File: rtl/debug_ocimem_ctrl.sv
// JTAG-driven debug RAM monitor: address/data registers, single-shot RAM read/write, sticky error.
// Optional write protection of the upper address half: define DEBUG_OCIMEM_WRPROT_EN.
module debug_ocimem_ctrl
  import debug_ocimem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata
);

  state_e            r_state;
  logic [1:0]        r_cnt;
  logic [31:0]       r_mon_data;
  logic [ADDR_W-1:0] r_mon_addr;
  logic              r_err;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic              r_ram_we;
  logic              r_ram_re;

  logic              w_idle;
  logic              w_do_a;
  logic              w_do_b;
  logic              w_do_na;
  logic              w_drop;
  logic              w_err_set;
  logic [ADDR_W-1:0] w_jdo_addr;
  logic [31:0]       w_jdo_wdata;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_unused;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_jdo_addr  = jdo[ADDR_LSB +: ADDR_W];
  assign w_jdo_wdata = jdo[WDATA_LSB +: 32];
  assign w_addr_inc  = r_mon_addr + ADDR_W'(1);
  assign w_unused    = &{1'b0, jdo[37:36], jdo[2:0]};

  // Priority b > a > no_action; any strobe that does not win (or arrives while busy) is an error.
  assign w_do_b  = w_idle & take_action_ocimem_b;
  assign w_do_a  = w_idle & take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_do_na = w_idle & take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_drop  = w_idle
                 ? ((take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a))
                    | (take_action_ocimem_a & take_no_action_ocimem_a))
                 : (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a);

`ifdef DEBUG_OCIMEM_WRPROT_EN
  assign w_err_set = w_drop | (w_do_b & r_mon_addr[ADDR_W-1]);
`else
  assign w_err_set = w_drop;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_mon_data  <= 32'd0;
      r_mon_addr  <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'd0;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      r_ram_re <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_do_b) begin
            r_mon_data  <= w_jdo_wdata;
            r_ram_wdata <= w_jdo_wdata;
            r_ram_addr  <= r_mon_addr;
`ifdef DEBUG_OCIMEM_WRPROT_EN
            r_ram_we    <= ~r_mon_addr[ADDR_W-1];
`else
            r_ram_we    <= 1'b1;
`endif
            r_state     <= ST_WR;
          end else if (w_do_a) begin
            r_mon_addr <= w_jdo_addr;
            if (jdo[RD_REQ_BIT]) begin
              r_ram_re   <= 1'b1;
              r_ram_addr <= w_jdo_addr;
              r_cnt      <= 2'd0;
              r_state    <= ST_RD_WAIT;
            end
          end else if (w_do_na) begin
            r_mon_addr <= w_addr_inc;
            r_ram_re   <= 1'b1;
            r_ram_addr <= w_addr_inc;
            r_cnt      <= 2'd0;
            r_state    <= ST_RD_WAIT;
          end
        end
        // Read data is valid RD_LATENCY cycles after the ram_re cycle.
        ST_RD_WAIT: begin
          if (r_cnt == 2'(RD_LATENCY)) begin
            r_mon_data <= ram_rdata;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_WR: begin
          r_mon_addr <= w_addr_inc;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A losing or late strobe wins over a simultaneous clear so no error is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_do_a && jdo[CLR_ERR_BIT]) begin
      r_err <= 1'b0;
    end
  end

  assign MonDReg       = r_mon_data;
  assign MonAReg       = r_mon_addr;
  assign monitor_ready = w_idle;
  assign monitor_error = r_err;
  assign ram_addr      = r_ram_addr;
  assign ram_wdata     = r_ram_wdata;
  assign ram_we        = r_ram_we;
  assign ram_re        = r_ram_re;

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Scoreboarded bench for debug_ocimem_ctrl with a behavioural 1-cycle-latency debug RAM.
module tb_debug_ocimem_ctrl;

  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic [37:0]   jdo;
  logic          s_a;
  logic          s_b;
  logic          s_na;
  logic [31:0]   mon_d;
  logic [AW-1:0] mon_a;
  logic          mon_rdy;
  logic          mon_err;

  debug_ocimem_ctrl_if #(.ADDR_W(AW)) ram_if ();

  debug_ocimem_ctrl #(.ADDR_W(AW), .RD_LATENCY(1)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (s_a),
    .take_action_ocimem_b    (s_b),
    .take_no_action_ocimem_a (s_na),
    .MonDReg                 (mon_d),
    .MonAReg                 (mon_a),
    .monitor_ready           (mon_rdy),
    .monitor_error           (mon_err),
    .ram_addr                (ram_if.ram_addr),
    .ram_wdata               (ram_if.ram_wdata),
    .ram_we                  (ram_if.ram_we),
    .ram_re                  (ram_if.ram_re),
    .ram_rdata               (ram_if.ram_rdata)
  );

  int            n_checks;
  int            n_fail;
  int            cyc;
  int            t_issue;
  logic          mon_en;
  logic          prev_rdy;
  logic [AW-1:0] m_addr;
  logic          m_err;
  logic [31:0]   mem [0:255];

  // {cycle, addr} / {cycle, addr, data} / {cycle, MonAReg, MonDReg, monitor_error}
  logic [23:0]   exp_rd_q[$];
  logic [55:0]   exp_wr_q[$];
  logic [56:0]   exp_done_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[35] = clr;
    j[34] = rd;
    j[17 +: 8] = addr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[3 +: 32] = data;
    return j;
  endfunction

  task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
    @(posedge clk); #1;
    jdo = j; s_a = a; s_b = b; s_na = na;
    t_issue = cyc;
    @(posedge clk); #1;
    jdo = '0; s_a = 1'b0; s_b = 1'b0; s_na = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mon_rdy && n < 20);
    chk("idle_timeout", 64'(mon_rdy), 64'(1));
  endtask

  task automatic rd_a(input logic [7:0] addr, input logic clr, input logic [31:0] data);
    m_addr = addr;
    if (clr) m_err = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, mk_a(addr, 1'b1, clr));
    exp_rd_q.push_back({16'(t_issue + 1), addr});
    exp_done_q.push_back({16'(t_issue + 3), addr, data, m_err});
  endtask

  task automatic rd_na(input logic [31:0] data);
    m_addr = m_addr + 8'd1;
    pulse(1'b0, 1'b0, 1'b1, '0);
    exp_rd_q.push_back({16'(t_issue + 1), m_addr});
    exp_done_q.push_back({16'(t_issue + 3), m_addr, data, m_err});
  endtask

  task automatic wr_b(input logic [31:0] data);
    pulse(1'b0, 1'b1, 1'b0, mk_b(data));
`ifdef DEBUG_OCIMEM_WRPROT_EN
    if (m_addr[7]) m_err = 1'b1;
    else exp_wr_q.push_back({16'(t_issue + 1), m_addr, data});
`else
    exp_wr_q.push_back({16'(t_issue + 1), m_addr, data});
`endif
    m_addr = m_addr + 8'd1;
    exp_done_q.push_back({16'(t_issue + 2), m_addr, data, m_err});
  endtask

  task automatic a_only(input logic [7:0] addr, input logic clr);
    m_addr = addr;
    if (clr) m_err = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, mk_a(addr, 1'b0, clr));
    @(negedge clk);
    chk("a_only_addr", 64'(mon_a), 64'(addr));
    chk("a_only_err", 64'(mon_err), 64'(m_err));
    chk("a_only_ready", 64'(mon_rdy), 64'(1));
  endtask

  initial begin
    logic [63:0] e;
    n_checks = 0; n_fail = 0; cyc = 0; mon_en = 1'b0; prev_rdy = 1'b1;
    m_addr = '0; m_err = 1'b0;
    reset = 1'b1; jdo = '0; s_a = 1'b0; s_b = 1'b0; s_na = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h11] = 32'h0000_1111;
    mem[8'h01] = 32'hA5A5_0001;
    mem[8'h20] = 32'h0BAD_F00D;
    mem[8'h21] = 32'h1111_2222;
    ram_if.ram_rdata = 32'd0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
        if (cyc > 5000) begin
          $display("FAIL watchdog: got cycle %0d, expected completion before 5000", cyc);
          $fatal(1, "watchdog expired");
        end
      end
      forever begin
        @(posedge clk);
        if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_wdata;
        if (ram_if.ram_re) ram_if.ram_rdata <= mem[ram_if.ram_addr];
      end
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (ram_if.ram_we || ram_if.ram_re)
            chk("we_re_exclusive", 64'(ram_if.ram_we & ram_if.ram_re), 64'(0));
          if (ram_if.ram_re) begin
            chk("ram_re_expected", 64'(exp_rd_q.size() != 0), 64'(1));
            if (exp_rd_q.size() != 0)
              chk("ram_re_cyc_addr", 64'({16'(cyc), ram_if.ram_addr}), 64'(exp_rd_q.pop_front()));
          end
          if (ram_if.ram_we) begin
            chk("ram_we_expected", 64'(exp_wr_q.size() != 0), 64'(1));
            if (exp_wr_q.size() != 0)
              chk("ram_we_cyc_addr_data", 64'({16'(cyc), ram_if.ram_addr, ram_if.ram_wdata}),
                  64'(exp_wr_q.pop_front()));
          end
          if (mon_rdy && !prev_rdy && !reset) begin
            chk("done_expected", 64'(exp_done_q.size() != 0), 64'(1));
            if (exp_done_q.size() != 0)
              chk("done_cyc_areg_dreg_err", 64'({16'(cyc), mon_a, mon_d, mon_err}),
                  64'(exp_done_q.pop_front()));
          end
          prev_rdy = mon_rdy;
        end
      end
    join_none

    // Reset held for two edges, then every output at its reset value.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_MonDReg", 64'(mon_d), 64'(0));
    chk("rst_MonAReg", 64'(mon_a), 64'(0));
    chk("rst_ready", 64'(mon_rdy), 64'(1));
    chk("rst_error", 64'(mon_err), 64'(0));
    chk("rst_ram_we", 64'(ram_if.ram_we), 64'(0));
    chk("rst_ram_re", 64'(ram_if.ram_re), 64'(0));
    chk("rst_ram_addr", 64'(ram_if.ram_addr), 64'(0));
    chk("rst_ram_wdata", 64'(ram_if.ram_wdata), 64'(0));
    prev_rdy = mon_rdy;
    mon_en = 1'b1;

    rd_a(8'h10, 1'b0, 32'hDEADBEEF);
    wait_idle();
    rd_na(32'h0000_1111);
    wait_idle();

    a_only(8'hFF, 1'b0);
    wr_b(32'h12345678);
    wait_idle();
    rd_na(32'hA5A5_0001);
    wait_idle();
    rd_a(8'hFF, 1'b0, 32'h12345678);
    wait_idle();

    // Write strobe while a read is in flight: dropped, error raised, read unaffected.
    m_err = 1'b1;
    rd_a(8'h20, 1'b0, 32'h0BAD_F00D);
    pulse(1'b0, 1'b1, 1'b0, mk_b(32'hCAFE_0000));
    wait_idle();
    chk("busy_drop_MonDReg", 64'(mon_d), 64'(32'h0BAD_F00D));
    chk("busy_drop_MonAReg", 64'(mon_a), 64'(8'h20));
    rd_a(8'h21, 1'b1, 32'h1111_2222);
    wait_idle();

    // a and b together: only the write at the current address happens.
    pulse(1'b1, 1'b1, 1'b0, mk_b(32'h5555_AAAA));
    exp_wr_q.push_back({16'(t_issue + 1), m_addr, 32'h5555_AAAA});
    m_addr = m_addr + 8'd1;
    m_err = 1'b1;
    exp_done_q.push_back({16'(t_issue + 2), m_addr, 32'h5555_AAAA, m_err});
    wait_idle();
    a_only(8'h30, 1'b1);

    // a and no_action together: the read from a wins, no_action flags an error.
    m_addr = 8'h10;
    m_err = 1'b1;
    pulse(1'b1, 1'b0, 1'b1, mk_a(8'h10, 1'b1, 1'b0));
    exp_rd_q.push_back({16'(t_issue + 1), 8'h10});
    exp_done_q.push_back({16'(t_issue + 3), 8'h10, 32'hDEADBEEF, 1'b1});
    wait_idle();
    rd_a(8'h10, 1'b1, 32'hDEADBEEF);
    wait_idle();

    // Upper-half address write; protected only when the write-protect build is selected.
    a_only(8'h80, 1'b0);
    wr_b(32'h0F0F_0F0F);
    wait_idle();
    chk("wr80_MonAReg", 64'(mon_a), 64'(8'h81));
    chk("wr80_error", 64'(mon_err), 64'(m_err));
`ifdef DEBUG_OCIMEM_WRPROT_EN
    rd_a(8'h80, 1'b1, 32'h0000_0000);
`else
    rd_a(8'h80, 1'b1, 32'h0F0F_0F0F);
`endif
    wait_idle();

    // Reset during RD_WAIT aborts the read.
    rd_a(8'h10, 1'b0, 32'hDEADBEEF);
    void'(exp_done_q.pop_back());
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ram_re", 64'(ram_if.ram_re), 64'(0));
    chk("abort_ram_we", 64'(ram_if.ram_we), 64'(0));
    chk("abort_MonDReg", 64'(mon_d), 64'(0));
    chk("abort_MonAReg", 64'(mon_a), 64'(0));
    chk("abort_ready", 64'(mon_rdy), 64'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    m_addr = '0;
    m_err = 1'b0;
    @(negedge clk);
    chk("abort_no_capture", 64'(mon_d), 64'(0));
    rd_a(8'h01, 1'b0, 32'hA5A5_0001);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("rd_queue_drained", 64'(exp_rd_q.size()), 64'(0));
    chk("wr_queue_drained", 64'(exp_wr_q.size()), 64'(0));
    chk("done_queue_drained", 64'(exp_done_q.size()), 64'(0));
    e = 64'(n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, e);
    $finish;
  end

endmodule
